// File: rtl/imem_boot_loader.sv
// Instruction memory with boot loader: streams a program into RAM, then
// releases the core and serves zero-latency fetches (NOP when unloaded).
// Ports:
//   clk, reset
//   load_valid/load_data/load_last/load_ready : program stream
//   in_mem_addr/in_mem_en/in_mem              : core fetch
//   core_reset/boot_done/load_error/word_count : status
module imem_boot_loader #(
  parameter int          DEPTH    = 256,
  parameter int          AW       = 8,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic [31:0]   in_mem_addr,
  input  logic          in_mem_en,
  output logic [31:0]   in_mem,
  output logic          core_reset,
  output logic          boot_done,
  output logic          load_error,
  output logic [AW:0]   word_count
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_ERROR
  } state_e;

  localparam logic [AW-1:0] ONE_W  = AW'(1);
  localparam logic [AW:0]   ONE_C  = (AW+1)'(1);
  localparam logic [AW-1:0] LAST_W = AW'(DEPTH - 1);

  state_e        state_q;
  logic [AW-1:0] wptr_q;
  logic [AW:0]   count_q;
  logic          ready_q;
  logic          core_rst_q;
  logic          boot_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH];

  logic          accept_d;
  logic [AW-1:0] idx_d;
  logic          hi_zero_d;
  logic          hit_d;
  logic          unused_addr_lsb;

  // ready_q is only ever high in LOAD, so it alone qualifies a beat.
  assign accept_d = load_valid & ready_q & ~reset
                  & (state_q == S_LOAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_LOAD;
      wptr_q     <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      core_rst_q <= 1'b1;
      boot_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          ready_q <= 1'b1;
          if (accept_d) begin
            wptr_q  <= wptr_q + ONE_W;
            count_q <= count_q + ONE_C;
            if (load_last) begin
              state_q    <= S_RUN;
              core_rst_q <= 1'b0;
              boot_q     <= 1'b1;
              ready_q    <= 1'b0;
            end else if (wptr_q == LAST_W) begin
              // RAM full with no end marker: stop here.
              state_q <= S_ERROR;
              ready_q <= 1'b0;
              err_q   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          ready_q <= 1'b0;
        end
        S_ERROR: begin
          ready_q    <= 1'b0;
          core_rst_q <= 1'b1;
          err_q      <= 1'b1;
        end
        default: begin
          state_q <= S_LOAD;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Program RAM is never cleared; word_count gates what is visible.
  always_ff @(posedge clk) begin
    if (accept_d) begin
      mem[wptr_q] <= load_data;
    end
  end

  assign idx_d     = in_mem_addr[AW+1:2];
  assign hi_zero_d = (in_mem_addr[31:AW+2] == '0);
  assign hit_d     = (state_q == S_RUN) & in_mem_en & hi_zero_d
                   & ({1'b0, idx_d} < count_q);

  assign unused_addr_lsb = ^in_mem_addr[1:0];

  always_comb begin
    in_mem = NOP_WORD;
    if (hit_d) begin
      in_mem = mem[idx_d];
    end
  end

  assign load_ready = ready_q;
  assign core_reset = core_rst_q;
  assign boot_done  = boot_q;
  assign load_error = err_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: a DEPTH=256 and a DEPTH=4 instance,
// checked every cycle against a behavioural program-image model.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic        lv   [2];
  logic [31:0] ld   [2];
  logic        ll   [2];
  logic [31:0] addr [2];
  logic        en   [2];

  logic        rdy  [2];
  logic [31:0] imem [2];
  logic        crst [2];
  logic        bd   [2];
  logic        le   [2];
  logic [8:0]  wc0;
  logic [2:0]  wc1;

  int checks = 0;
  int errors = 0;

  imem_boot_loader #(.DEPTH(256), .AW(8)) u_big (
    .clk(clk), .reset(rst[0]),
    .load_valid(lv[0]), .load_data(ld[0]),
    .load_last(ll[0]), .load_ready(rdy[0]),
    .in_mem_addr(addr[0]), .in_mem_en(en[0]),
    .in_mem(imem[0]), .core_reset(crst[0]),
    .boot_done(bd[0]), .load_error(le[0]),
    .word_count(wc0)
  );

  imem_boot_loader #(.DEPTH(4), .AW(2)) u_small (
    .clk(clk), .reset(rst[1]),
    .load_valid(lv[1]), .load_data(ld[1]),
    .load_last(ll[1]), .load_ready(rdy[1]),
    .in_mem_addr(addr[1]), .in_mem_en(en[1]),
    .in_mem(imem[1]), .core_reset(crst[1]),
    .boot_done(bd[1]), .load_error(le[1]),
    .word_count(wc1)
  );

  // Model: mode 0=loading 1=running 2=overflowed
  int          m_mode  [2];
  int          m_cnt   [2];
  bit          m_fresh [2];
  bit          m_init  [2] = '{0, 0};
  logic [31:0] m_img   [2][256];

  function automatic int depth_of(int k);
    return (k == 0) ? 256 : 4;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        m_init[k]  = 1'b1;
        m_mode[k]  = 0;
        m_cnt[k]   = 0;
        m_fresh[k] = 1'b1;
      end else if (m_init[k] && m_mode[k] == 0) begin
        if (!m_fresh[k] && lv[k]) begin
          m_img[k][m_cnt[k]] = ld[k];
          m_cnt[k]++;
          if (ll[k]) m_mode[k] = 1;
          else if (m_cnt[k] == depth_of(k)) m_mode[k] = 2;
        end
        m_fresh[k] = 1'b0;
      end
    end
  end

  function automatic logic [31:0] exp_fetch(int k);
    longint a = longint'(addr[k]);
    if (m_mode[k] == 1 && en[k] === 1'b1 &&
        a < longint'(m_cnt[k]) * 4)
      return m_img[k][int'(a >> 2)];
    return 32'h0;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_init[k]) begin
        logic [31:0] wc;
        wc = (k == 0) ? {23'b0, wc0} : {29'b0, wc1};
        chk($sformatf("ready[%0d]", k), {31'b0, rdy[k]},
            {31'b0, (m_mode[k] == 0 && !m_fresh[k])});
        chk($sformatf("core_reset[%0d]", k), {31'b0, crst[k]},
            {31'b0, (m_mode[k] != 1)});
        chk($sformatf("boot_done[%0d]", k), {31'b0, bd[k]},
            {31'b0, (m_mode[k] == 1)});
        chk($sformatf("load_error[%0d]", k), {31'b0, le[k]},
            {31'b0, (m_mode[k] == 2)});
        chk($sformatf("word_count[%0d]", k), wc, m_cnt[k]);
        chk($sformatf("in_mem[%0d]", k), imem[k], exp_fetch(k));
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(int k, logic [31:0] d, logic last);
    lv[k] = 1'b1; ld[k] = d; ll[k] = last;
    tick();
    lv[k] = 1'b0; ll[k] = 1'b0;
  endtask

  task automatic fetch(int k, logic [31:0] a, logic e,
                       logic [31:0] exp, string nm);
    addr[k] = a; en[k] = e;
    #1;
    chk(nm, imem[k], exp);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; lv[k] = 1'b0; ld[k] = '0;
      ll[k] = 1'b0; addr[k] = '0; en[k] = 1'b0;
    end

    // Big DUT: reset with a beat pending
    rst[0] = 1'b1; lv[0] = 1'b1; ld[0] = 32'hBAD0BAD0;
    tick(2);
    chk("rst_ready", {31'b0, rdy[0]}, 32'd0);
    chk("rst_core_reset", {31'b0, crst[0]}, 32'd1);
    chk("rst_wc", {23'b0, wc0}, 32'd0);
    rst[0] = 1'b0;
    tick();
    lv[0] = 1'b0;
    chk("ready_up", {31'b0, rdy[0]}, 32'd1);
    chk("no_accept_in_reset", {23'b0, wc0}, 32'd0);

    beat(0, 32'h11111111, 1'b0);
    tick(5);
    chk("wc_after_gap", {23'b0, wc0}, 32'd1);
    beat(0, 32'h22222222, 1'b0);
    beat(0, 32'h33333333, 1'b1);
    chk("boot_core_reset", {31'b0, crst[0]}, 32'd0);
    chk("boot_done", {31'b0, bd[0]}, 32'd1);
    chk("boot_wc", {23'b0, wc0}, 32'd3);

    fetch(0, 32'h8, 1'b1, 32'h33333333, "fetch_8");
    fetch(0, 32'h9, 1'b1, 32'h33333333, "fetch_9");
    fetch(0, 32'h0, 1'b1, 32'h11111111, "fetch_0");
    fetch(0, 32'hC, 1'b1, 32'h0, "fetch_C");
    fetch(0, 32'h400, 1'b1, 32'h0, "fetch_400");
    fetch(0, 32'h8000_0004, 1'b1, 32'h0, "fetch_hi");
    fetch(0, 32'h0, 1'b0, 32'h0, "fetch_en0");

    // Load attempts while running are ignored
    addr[0] = 32'h4; en[0] = 1'b1;
    lv[0] = 1'b1; ld[0] = 32'hDEADBEEF; ll[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("run_ready", {31'b0, rdy[0]}, 32'd0);
      chk("run_in_mem", imem[0], 32'h22222222);
      chk("run_wc", {23'b0, wc0}, 32'd3);
    end
    lv[0] = 1'b0;

    // Reset mid-load, then a fresh 2-word program
    rst[0] = 1'b1; tick(); rst[0] = 1'b0; tick();
    beat(0, 32'hAAAA0000, 1'b0);
    beat(0, 32'hBBBB0000, 1'b0);
    rst[0] = 1'b1; tick(); rst[0] = 1'b0; tick();
    chk("reload_wc0", {23'b0, wc0}, 32'd0);
    beat(0, 32'h12340000, 1'b0);
    beat(0, 32'hABCD0001, 1'b1);
    chk("reload_wc", {23'b0, wc0}, 32'd2);
    chk("reload_boot", {31'b0, bd[0]}, 32'd1);
    fetch(0, 32'h4, 1'b1, 32'hABCD0001, "reload_f4");
    fetch(0, 32'h8, 1'b1, 32'h0, "reload_f8");
    fetch(0, 32'h0, 1'b1, 32'h12340000, "reload_f0");
    tick(2);

    // Small DUT: overflow without load_last
    rst[1] = 1'b1; tick(); rst[1] = 1'b0; tick();
    addr[1] = 32'h0; en[1] = 1'b1;
    beat(1, 32'h00000001, 1'b0);
    beat(1, 32'h00000002, 1'b0);
    beat(1, 32'h00000003, 1'b0);
    chk("ovf_pre_err", {31'b0, le[1]}, 32'd0);
    beat(1, 32'h00000004, 1'b0);
    chk("ovf_err", {31'b0, le[1]}, 32'd1);
    chk("ovf_ready", {31'b0, rdy[1]}, 32'd0);
    chk("ovf_core_reset", {31'b0, crst[1]}, 32'd1);
    chk("ovf_wc", {29'b0, wc1}, 32'd4);
    beat(1, 32'h00000005, 1'b0);
    beat(1, 32'h00000006, 1'b1);
    chk("ovf_sticky", {31'b0, le[1]}, 32'd1);
    chk("ovf_wc_hold", {29'b0, wc1}, 32'd4);
    fetch(1, 32'h0, 1'b1, 32'h0, "ovf_f0");
    fetch(1, 32'hC, 1'b1, 32'h0, "ovf_fC");

    // Small DUT: exactly-full program
    rst[1] = 1'b1; tick(); rst[1] = 1'b0; tick();
    chk("full_clr_err", {31'b0, le[1]}, 32'd0);
    beat(1, 32'hA0000000, 1'b0);
    beat(1, 32'hA0000001, 1'b0);
    beat(1, 32'hA0000002, 1'b0);
    beat(1, 32'hA0000003, 1'b1);
    chk("full_boot", {31'b0, bd[1]}, 32'd1);
    chk("full_err", {31'b0, le[1]}, 32'd0);
    chk("full_wc", {29'b0, wc1}, 32'd4);
    fetch(1, 32'hC, 1'b1, 32'hA0000003, "full_fC");
    fetch(1, 32'h10, 1'b1, 32'h0, "full_f10");
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
